axis_align: RTL and testbench
=============================

Name: axis_align

Overview:
- AXI4-Stream byte realigner. Packets may start with a partial first beat whose valid bytes sit in the upper lanes.
- The block removes the leading gap so each output packet starts at byte lane 0, with every non-last beat full and the last beat right-packed.
- Byte order is preserved: lower lane first, earlier beat first.
- Sits between a DMA/packet source and any consumer that requires lane-0-aligned streams.

Parameters:
- AXIS_DW, 64, data width in bits; multiple of 8, at least 8.
- AXIS_KW, ((AXIS_DW-1)>>3)+1, keep width in bytes; localparam, not overridable.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high together with tvalid.
- s_axis_tdata  in  AXIS_DW  input bytes; lane i is bits [8i+7:8i].
- s_axis_tkeep  in  AXIS_KW  input byte enables.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  AXIS_DW  aligned output bytes.
- m_axis_tkeep  out  AXIS_KW  output byte enables.
- m_axis_tlast  out  1  last beat of output packet.

Behaviour:
- Reset (async, rst=1): m_axis_tvalid/tdata/tkeep/tlast = 0; residual cleared; state IDLE; s_axis_tready = 0 while rst is high.
- Input contract:
  - First beat tkeep is contiguous ones ending at the MSB lane.
  - Middle beats are all ones.
  - Last beat (and any single-beat packet) is contiguous ones from lane 0.
  - tkeep is never 0.
- Shift s = index of the lowest set tkeep bit of the first beat. k = KW - s bytes are held in residual register R, lanes 0..k-1.
- Output register stage: a new output beat may be loaded when !m_axis_tvalid || m_axis_tready.
- s_axis_tready = output-loadable && state != FLUSH.
- Output holds stable while m_axis_tvalid && !m_axis_tready.
- State machine:
  - IDLE: accept first beat; R = first beat >> 8s; k latched.
    - If tlast: emit R with keep = popcount ones at the right, tlast=1; stay IDLE.
    - Else go STREAM. No output is produced for a non-last first beat.
  - STREAM, middle beat D (all ones): emit {D[lanes 0..s-1], R[lanes 0..k-1]}, keep all ones, tlast=0; R = D lanes s..KW-1.
  - STREAM, last beat with m valid bytes:
    - If k+m <= KW: emit R plus the m new bytes, keep = k+m ones from the right, tlast=1; go IDLE.
    - Else: emit a full beat (tlast=0), R = remaining k+m-KW bytes; go FLUSH.
  - FLUSH: input stalled. When output is loadable, emit R with keep = (k+m-KW) ones from the right, tlast=1; go IDLE.
- s=0 (full first beat) follows the same rules; the stream passes through delayed by one beat.
- Output beat count = ceil(total bytes / KW): equal to the input beat count, or one fewer.
- Output tkeep is never 0. Unused output lanes are driven 0.
- Latency: an output beat appears the cycle after the input edge that completes it.
- Throughput: one beat per clock in STREAM with m_axis_tready held high.
- Back-to-back packets: next packet's first beat is accepted in IDLE on the cycle after the previous packet's last output is loaded. Note: FLUSH costs one input stall cycle.
- Reset mid-packet discards residual and any pending output.

Test Plan:
- KW=8, single beat keep=0x0F, tlast=1 → one output beat, keep=0x0F, tlast=1, same 4 bytes in lanes 0..3.
- 3 beats, keeps 0xF0, 0xFF, 0x07 (4+8+3=15 bytes) → 2 outputs: keep 0xFF (tlast=0), then keep 0x7F (tlast=1); byte stream identical and in order.
- 3 beats, keeps 0xC0, 0xFF, 0xFF (18 bytes) → 3 outputs: 0xFF, 0xFF, 0x03 (tlast); FLUSH stalls s_axis_tready exactly one cycle.
- First keep 0xFF, 4 beats, last keep 0xFF → 4 full output beats, tlast on the 4th.
- Random tvalid/tready toggling over many random packets (1..255 beats) → data bytes match the input byte queue; keep byte totals equal per packet; output beats = input beats or one fewer; output tdata/tkeep/tlast unchanged while stalled.
- Assert rst mid-packet → outputs 0 immediately; next packet aligns correctly with no stale residual bytes.

Source files
------------

// File: rtl/axis_align.sv
// axis_align
// AXI4-Stream byte realigner. A packet may begin with a partial first beat
// whose valid bytes sit in the upper lanes. This block removes that leading
// gap, so each output packet starts at byte lane 0. Every non-last output
// beat is full, and the last output beat is right-packed. Byte order is
// preserved.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   s_axis_tvalid  input beat valid
//   s_axis_tready  input beat accepted when high together with tvalid
//   s_axis_tdata   input bytes, lane i = bits [8i+7:8i]
//   s_axis_tkeep   input byte enables
//   s_axis_tlast   last input beat of a packet
//   m_axis_tvalid  output beat valid (registered)
//   m_axis_tready  downstream ready
//   m_axis_tdata   aligned output bytes, unused lanes are 0
//   m_axis_tkeep   output byte enables, contiguous from lane 0
//   m_axis_tlast   last output beat of a packet
module axis_align #(
  parameter  int AXIS_DW = 64,
  localparam int AXIS_KW = ((AXIS_DW-1)>>3)+1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [AXIS_DW-1:0] s_axis_tdata,
  input  logic [AXIS_KW-1:0] s_axis_tkeep,
  input  logic               s_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [AXIS_DW-1:0] m_axis_tdata,
  output logic [AXIS_KW-1:0] m_axis_tkeep,
  output logic               m_axis_tlast
);

  localparam int CW = $clog2(AXIS_KW+1);
  localparam logic [CW-1:0] KW_C = CW'(AXIS_KW);
  localparam logic [CW:0]   KW_S = (CW+1)'(AXIS_KW);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  logic [1:0]           state;
  logic [AXIS_DW-1:0]   r_data;
  logic [CW-1:0]        r_cnt;

  logic                 out_loadable;
  logic                 in_fire;
  logic [AXIS_DW-1:0]   keep_mask;
  logic [AXIS_DW-1:0]   in_masked;
  logic [CW-1:0]        in_cnt;
  logic [CW-1:0]        in_low;
  logic [AXIS_DW-1:0]   first_shifted;
  logic [2*AXIS_DW-1:0] merged;
  logic [CW:0]          sum;
  logic [CW-1:0]        tail_cnt;

  // Keep mask of n ones starting at lane 0.
  function automatic logic [AXIS_KW-1:0] ones(input logic [CW:0] n);
    logic [AXIS_KW-1:0] t;
    t = '0;
    for (int i = 0; i < AXIS_KW; i++) begin
      if (i < int'(n)) t[i] = 1'b1;
    end
    return t;
  endfunction

  assign out_loadable  = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = !rst && out_loadable && (state != ST_FLUSH);
  assign in_fire       = s_axis_tvalid && s_axis_tready;

  // Bytes in disabled lanes are zeroed up front. This keeps garbage out of
  // the residual register and out of unused output lanes.
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < AXIS_KW; i++) begin
      keep_mask[8*i +: 8] = {8{s_axis_tkeep[i]}};
    end
  end

  assign in_masked = s_axis_tdata & keep_mask;

  // Byte count of the incoming beat and the index of its lowest valid lane.
  // The downward scan leaves in_low at the lowest set bit.
  always_comb begin
    in_cnt = '0;
    in_low = '0;
    for (int i = AXIS_KW-1; i >= 0; i--) begin
      if (s_axis_tkeep[i]) begin
        in_cnt = in_cnt + CW'(1);
        in_low = CW'(i);
      end
    end
  end

  // The first beat is shifted down so its lowest valid byte lands in lane 0.
  // In STREAM, new bytes are placed just above the k residual bytes.
  // The low half of merged is the next output beat. The high half holds
  // the bytes that carry over into the residual.
  assign first_shifted = in_masked >> {in_low, 3'b000};
  assign merged   = ({{AXIS_DW{1'b0}}, in_masked} << {r_cnt, 3'b000})
                  | {{AXIS_DW{1'b0}}, r_data};
  assign sum      = {1'b0, r_cnt} + {1'b0, in_cnt};
  // Bytes left over after a full beat = m - s, where s = KW - k.
  assign tail_cnt = in_cnt - (KW_C - r_cnt);

  // Main sequencer and output register.
  // A handshake retires the current output beat. A new beat is loaded only
  // when the output is loadable. The input side enforces this through
  // s_axis_tready, and FLUSH checks out_loadable directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      r_data        <= '0;
      r_cnt         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            if (s_axis_tlast) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= first_shifted;
              m_axis_tkeep  <= ones({1'b0, in_cnt});
              m_axis_tlast  <= 1'b1;
              r_data        <= '0;
              r_cnt         <= '0;
            end else begin
              r_data <= first_shifted;
              r_cnt  <= KW_C - in_low;
              state  <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (in_fire) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= merged[AXIS_DW-1:0];
            if (!s_axis_tlast) begin
              m_axis_tkeep <= '1;
              m_axis_tlast <= 1'b0;
              r_data       <= merged[2*AXIS_DW-1:AXIS_DW];
            end else if (sum <= KW_S) begin
              m_axis_tkeep <= ones(sum);
              m_axis_tlast <= 1'b1;
              r_data       <= '0;
              r_cnt        <= '0;
              state        <= ST_IDLE;
            end else begin
              // The residual plus the last beat overflow one beat.
              // The leftover bytes are emitted from FLUSH.
              m_axis_tkeep <= '1;
              m_axis_tlast <= 1'b0;
              r_data       <= merged[2*AXIS_DW-1:AXIS_DW];
              r_cnt        <= tail_cnt;
              state        <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (out_loadable) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= r_data;
            m_axis_tkeep  <= ones({1'b0, r_cnt});
            m_axis_tlast  <= 1'b1;
            r_data        <= '0;
            r_cnt         <= '0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_align.sv
// tb_axis_align
// Scoreboard bench for axis_align (64-bit data, 8 byte lanes).
// For each packet, the bench builds the input beats and, separately,
// the expected output beats. The expected beats come from chunking the
// packet byte stream into groups of 8, and they are queued. A negedge
// monitor pops one expected beat per output handshake and compares it.
// The monitor also checks that the output holds steady while stalled.
`timescale 1ns/1ps
module tb_axis_align;

  localparam int DW = 64;
  localparam int KW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [KW-1:0] s_keep;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_last;

  beat_t exp_q[$];
  beat_t in_q[$];
  beat_t mon_e;

  int checks = 0;
  int errors = 0;
  bit ignore_out = 1'b0;
  int ready_mode = 0;
  bit gaps = 1'b0;

  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [KW-1:0] prev_keep;
  logic          prev_last;

  axis_align #(.AXIS_DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep),
    .m_axis_tlast  (m_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Build one packet. s is the first-beat lane offset, nbeats is the beat
  // count, and m is the byte count of the last beat. For a single-beat
  // packet, m bytes start at lane 0. Disabled lanes carry random garbage.
  task automatic buildPacket(input int s, input int nbeats, input int m);
    logic [7:0] bytes[$];
    beat_t b;
    beat_t e;
    in_q.delete();
    for (int bi = 0; bi < nbeats; bi++) begin
      int lo;
      int hi;
      if (nbeats == 1)             begin lo = 0; hi = m-1;  end
      else if (bi == 0)            begin lo = s; hi = KW-1; end
      else if (bi == nbeats-1)     begin lo = 0; hi = m-1;  end
      else                         begin lo = 0; hi = KW-1; end
      b.data = {$urandom, $urandom};
      b.keep = '0;
      b.last = (bi == nbeats-1);
      for (int l = lo; l <= hi; l++) begin
        logic [7:0] v;
        v = 8'($urandom);
        b.data[8*l +: 8] = v;
        b.keep[l] = 1'b1;
        bytes.push_back(v);
      end
      in_q.push_back(b);
    end
    for (int i = 0; i < bytes.size(); i += KW) begin
      e.data = '0;
      e.keep = '0;
      for (int j = 0; j < KW && i+j < bytes.size(); j++) begin
        e.data[8*j +: 8] = bytes[i+j];
        e.keep[j] = 1'b1;
      end
      e.last = (i + KW >= bytes.size());
      exp_q.push_back(e);
    end
  endtask

  // Drive the beats in in_q, with optional idle gaps. Each task call
  // returns #1 after the clock edge that accepted the last beat.
  task automatic applyStimulus();
    foreach (in_q[i]) begin
      bit acc;
      int cyc;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_valid = 1'b1;
      s_data  = in_q[i].data;
      s_keep  = in_q[i].keep;
      s_last  = in_q[i].last;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 1000) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #1;
        cyc++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("[TB] FAIL input_accept_timeout: beat %0d not accepted after %0d cycles", i, cyc);
      end
      s_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || m_valid) && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("drain_pending_beats", 64'(exp_q.size()), 64'd0);
  endtask

  // Downstream ready: always high in mode 0, random in mode 1.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
    end
  end

  // Output monitor. Sampling at negedge sees the values that the next rising
  // edge will use for the handshake.
  always @(negedge clk) begin
    if (!rst && !ignore_out) begin
      if (prev_stall) begin
        checkOutput("hold_valid", 64'(m_valid), 64'd1);
        checkOutput("hold_data",  m_data, prev_data);
        checkOutput("hold_keep",  64'(m_keep), 64'(prev_keep));
        checkOutput("hold_last",  64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got data %h keep %h last %b, expected no beat", m_data, m_keep, m_last);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("out_data", m_data, mon_e.data);
          checkOutput("out_keep", 64'(m_keep), 64'(mon_e.keep));
          checkOutput("out_last", 64'(m_last), 64'(mon_e.last));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_keep  = m_keep;
      prev_last  = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_m_valid", 64'(m_valid), 64'd0);
    checkOutput("reset_m_data",  m_data, 64'd0);
    checkOutput("reset_m_keep",  64'(m_keep), 64'd0);
    checkOutput("reset_m_last",  64'(m_last), 64'd0);
    checkOutput("reset_s_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed packets with downstream always ready.
    ready_mode = 0;
    gaps = 1'b0;
    buildPacket(0, 1, 4);
    applyStimulus();
    buildPacket(4, 3, 3);
    applyStimulus();
    checkOutput("no_flush_ready", 64'(s_ready), 64'd1);
    buildPacket(6, 3, 8);
    applyStimulus();
    checkOutput("flush_stall", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("flush_release", 64'(s_ready), 64'd1);
    buildPacket(0, 4, 8);
    applyStimulus();
    buildPacket(7, 2, 1);
    applyStimulus();
    waitDrain();

    // Random packets with random valid gaps and random downstream ready.
    ready_mode = 1;
    gaps = 1'b1;
    for (int p = 0; p < 20; p++) begin
      buildPacket($urandom_range(0, KW-1), (p == 10) ? 255 : $urandom_range(1, 30),
                  $urandom_range(1, KW));
      applyStimulus();
    end
    ready_mode = 0;
    waitDrain();

    // Reset in the middle of a packet. Outputs seen before the reset are ignored.
    gaps = 1'b0;
    ignore_out = 1'b1;
    buildPacket(5, 4, 2);
    exp_q.delete();
    void'(in_q.pop_back());
    applyStimulus();
    checkOutput("prereset_valid", 64'(m_valid), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_m_valid", 64'(m_valid), 64'd0);
    checkOutput("midreset_m_data",  m_data, 64'd0);
    checkOutput("midreset_m_keep",  64'(m_keep), 64'd0);
    checkOutput("midreset_m_last",  64'(m_last), 64'd0);
    checkOutput("midreset_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ignore_out = 1'b0;
    buildPacket(3, 3, 5);
    applyStimulus();
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
